fifo_rr_read_scheduler: RTL and testbench

- Round-robin read scheduler that drains CH_N single-clock FWFT FIFOs into one shared output stream.
- Issues per-channel r_req pulses and muxes the granted channel's head word into a registered output stage with a valid/ready handshake.
- A per-grant burst quota bounds how long one channel holds the output.
- Sits between a bank of per-source FIFOs and a single downstream consumer, e.g. a serializer or DMA.

---
 rtl/fifo_rr_sched_pkg.sv | 21 ++
 rtl/fifo_rr_read_scheduler_rr_pick.sv | 34 +++
 rtl/fifo_rr_read_scheduler.sv | 176 +++++++++++++++++
 tb/tb_fifo_rr_read_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO read scheduler.
package fifo_rr_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } sched_state_e;

    // Index width for n items, never less than one bit.
    function automatic int clogb2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rr_read_scheduler_rr_pick.sv
// Combinational round-robin find-first: searches ptr+1, ptr+2, ... (mod N),
// with ptr itself checked last.
module rr_pick
    import fifo_rr_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clogb2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = N; i >= 1; i--) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (req[cand[IDX_W-1:0]]) begin
                hit = 1'b1;
                idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_rr_read_scheduler.sv
// Round-robin read scheduler draining CH_N FWFT FIFOs into one registered
// valid/ready output stream, with a per-grant burst quota.
// Optional per-channel saturating read counters: FIFO_RR_SCHED_STATS_EN.
//
//   state | meaning
//   IDLE  | one-cycle arbitration, searching from ptr+1 for a ready channel
//   SERVE | reading the granted channel until quota, empty or disable
module fifo_rr_read_scheduler
    import fifo_rr_sched_pkg::*;
#(
    parameter int CH_N      = 4,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4,
    parameter int CH_W      = clogb2(CH_N),
    parameter int STAT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_N-1:0]          ch_empty,
    input  logic [CH_N*DATA_W-1:0]   ch_data,
    input  logic [CH_N-1:0]          ch_enable,
    output logic [CH_N-1:0]          ch_r_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     busy
`ifdef FIFO_RR_SCHED_STATS_EN
    ,
    output logic [CH_N*STAT_W-1:0]   stat_cnt
`endif
);

    localparam int CNT_W = clogb2(BURST_MAX + 1);

    sched_state_e        state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CH_W-1:0]     gnt_q, gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;

    logic                load;
    logic                rd;
    logic                gnt_empty;
    logic                gnt_enable;
    logic [DATA_W-1:0]   gnt_data;
    logic                pick_hit;
    logic [CH_W-1:0]     pick_idx;

    assign load       = ~out_valid_q | out_ready;
    assign gnt_empty  = ch_empty[gnt_q];
    assign gnt_enable = ch_enable[gnt_q];
    assign gnt_data   = ch_data[gnt_q*DATA_W +: DATA_W];
    assign rd         = (state_q == SERVE) & load & ~gnt_empty & gnt_enable;

    rr_pick #(
        .N     (CH_N),
        .IDX_W (CH_W)
    ) u_pick (
        .req (ch_enable & ~ch_empty),
        .ptr (ptr_q),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    // Single read strobe toward the granted FIFO.
    always_comb begin
        ch_r_req = '0;
        if (rd) begin
            ch_r_req[gnt_q] = 1'b1;
        end
    end

    // Next-state, grant, burst count and output register load.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;

        unique case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    gnt_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (rd) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Quota reached, FIFO dried up on a load cycle, or channel disabled.
                if ((rd && cnt_q == CNT_W'(BURST_MAX - 1)) ||
                    (load && gnt_empty) ||
                    !gnt_enable) begin
                    state_d = IDLE;
                    ptr_d   = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_ch_d    = gnt_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset drops everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= CH_W'(CH_N - 1);
            gnt_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q != IDLE) | out_valid_q;

`ifdef FIFO_RR_SCHED_STATS_EN
    logic [STAT_W-1:0] stat_q [CH_N];
    logic [STAT_W-1:0] stat_d [CH_N];

    // Saturating per-channel read counters.
    always_comb begin
        for (int c = 0; c < CH_N; c++) begin
            stat_d[c] = stat_q[c];
            if (ch_r_req[c] && stat_q[c] != {STAT_W{1'b1}}) begin
                stat_d[c] = stat_q[c] + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH_N; c++) begin
                stat_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH_N; c++) begin
                stat_q[c] <= stat_d[c];
            end
        end
    end

    for (genvar g = 0; g < CH_N; g++) begin : g_stat
        assign stat_cnt[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_fifo_rr_read_scheduler.sv
// Directed bench for fifo_rr_read_scheduler with behavioural FWFT FIFOs
// and an always-logging sink.
module tb_fifo_rr_read_scheduler;

    localparam int CH_N      = 4;
    localparam int DATA_W    = 32;
    localparam int BURST_MAX = 4;
    localparam int CH_W      = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [CH_N-1:0]        ch_empty;
    logic [CH_N*DATA_W-1:0] ch_data;
    logic [CH_N-1:0]        ch_enable;
    logic [CH_N-1:0]        ch_r_req;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic [CH_W-1:0]        out_ch;
    logic                   busy;
`ifdef FIFO_RR_SCHED_STATS_EN
    logic [CH_N*4-1:0]      stat_cnt;
`endif

    fifo_rr_read_scheduler #(
        .CH_N      (CH_N),
        .DATA_W    (DATA_W),
        .BURST_MAX (BURST_MAX)
`ifdef FIFO_RR_SCHED_STATS_EN
        ,
        .STAT_W    (4)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_empty  (ch_empty),
        .ch_data   (ch_data),
        .ch_enable (ch_enable),
        .ch_r_req  (ch_r_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .busy      (busy)
`ifdef FIFO_RR_SCHED_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model: mem/wr written by tasks, rd advanced only on read strobes.
    logic [DATA_W-1:0] mem [CH_N][32];
    int wr [CH_N];
    int rd [CH_N];
    int rd_empty_err = 0;

    always_comb begin
        for (int c = 0; c < CH_N; c++) begin
            ch_empty[c] = (wr[c] == rd[c]);
            ch_data[c*DATA_W +: DATA_W] = mem[c][rd[c][4:0]];
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < CH_N; c++) begin
            if (ch_r_req[c]) begin
                if (wr[c] == rd[c]) rd_empty_err = rd_empty_err + 1;
                rd[c] <= rd[c] + 1;
            end
        end
    end

    // Sink log.
    int cyc = 0;
    int acc_n = 0;
    int rreq1_n = 0;
    logic [DATA_W-1:0] acc_word [256];
    logic [CH_W-1:0]   acc_ch   [256];
    int                acc_cyc  [256];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ch_r_req[1]) rreq1_n <= rreq1_n + 1;
        if (!rst && out_valid && out_ready && acc_n < 256) begin
            acc_word[acc_n] <= out_data;
            acc_ch[acc_n]   <= out_ch;
            acc_cyc[acc_n]  <= cyc;
            acc_n           <= acc_n + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [DATA_W-1:0] wv(input int c, input int k);
        return 32'hA500_0000 | DATA_W'(c << 8) | DATA_W'(k);
    endfunction

    task automatic push(input int c, input int k);
        mem[c][wr[c][4:0]] = wv(c, k);
        wr[c] = wr[c] + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        ch_enable = '1;
        for (int c = 0; c < CH_N; c++) wr[c] = rd[c];
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_acc(input int target, input int budget, input string name);
        int b;
        b = 0;
        while (acc_n < target && b < budget) begin
            @(negedge clk);
            b++;
        end
        n_chk++;
        if (acc_n < target) $display("FAIL %s_timeout: got %0d words, expected %0d", name, acc_n, target);
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        ch_enable = '1;
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", out_valid); else n_pass++;
        n_chk++; if (ch_r_req !== 4'b0) $display("FAIL rst_rreq: got %b expected 0000", ch_r_req); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_chk++; if (out_data !== 32'h0) $display("FAIL rst_data: got %h expected 0", out_data); else n_pass++;
        n_chk++; if (out_ch !== 2'd0) $display("FAIL rst_ch: got %0d expected 0", out_ch); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_burst_quota();
        int base;
        do_reset();
        base = acc_n;
        for (int k = 0; k < 6; k++) push(0, k);
        wait_acc(base + 6, 40, "quota");
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (acc_word[base+i] !== wv(0, i) || acc_ch[base+i] !== 2'd0)
                $display("FAIL quota_word%0d: got ch%0d %h expected ch0 %h", i, acc_ch[base+i], acc_word[base+i], wv(0, i));
            else n_pass++;
        end
        for (int i = 1; i < 6; i++) begin
            n_chk++;
            if ((acc_cyc[base+i] - acc_cyc[base+i-1]) !== ((i == 4) ? 2 : 1))
                $display("FAIL quota_gap%0d: got %0d cycles expected %0d", i,
                         acc_cyc[base+i] - acc_cyc[base+i-1], (i == 4) ? 2 : 1);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL quota_idle: busy got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_round_robin();
        int base;
        do_reset();
        base = acc_n;
        for (int c = 0; c < CH_N; c++) begin
            push(c, 0);
            push(c, 1);
        end
        wait_acc(base + 8, 60, "rr");
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (acc_ch[base+i] !== CH_W'(i / 2) || acc_word[base+i] !== wv(i / 2, i % 2))
                $display("FAIL rr_word%0d: got ch%0d %h expected ch%0d %h", i, acc_ch[base+i],
                         acc_word[base+i], i / 2, wv(i / 2, i % 2));
            else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_chk++; if (acc_n !== base + 8) $display("FAIL rr_count: got %0d expected %0d", acc_n - base, 8); else n_pass++;
    endtask

    task automatic test_backpressure();
        int base;
        do_reset();
        base = acc_n;
        for (int k = 0; k < 4; k++) push(1, k);
        wait_acc(base + 2, 30, "bp_start");
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== wv(1, 2) || out_ch !== 2'd1)
                $display("FAIL bp_hold%0d: got v%b ch%0d %h expected v1 ch1 %h", s, out_valid, out_ch, out_data, wv(1, 2));
            else n_pass++;
            n_chk++;
            if (ch_r_req !== 4'b0) $display("FAIL bp_rreq%0d: got %b expected 0000", s, ch_r_req); else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_acc(base + 4, 30, "bp_end");
        repeat (3) @(negedge clk);
        n_chk++; if (acc_n !== base + 4) $display("FAIL bp_count: got %0d expected 4", acc_n - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (acc_word[base+i] !== wv(1, i) || acc_ch[base+i] !== 2'd1)
                $display("FAIL bp_word%0d: got ch%0d %h expected ch1 %h", i, acc_ch[base+i], acc_word[base+i], wv(1, i));
            else n_pass++;
        end
    endtask

    task automatic test_enable_drop();
        int base;
        int b;
        int r1;
        logic [DATA_W-1:0] exp_w [7];
        logic [CH_W-1:0]   exp_c [7];
        do_reset();
        base = acc_n;
        for (int k = 0; k < 5; k++) push(1, k);
        b = 0;
        while ((wr[1] - rd[1]) != 3 && b < 30) begin
            @(negedge clk);
            b++;
        end
        n_chk++; if ((wr[1] - rd[1]) !== 3) $display("FAIL en_reach: got %0d left expected 3", wr[1] - rd[1]); else n_pass++;
        ch_enable[1] = 1'b0;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL en_exit: busy got %b expected 0", busy); else n_pass++;
        r1 = rreq1_n;
        push(2, 0);
        push(2, 1);
        wait_acc(base + 4, 30, "en_ch2");
        repeat (6) @(negedge clk);
        n_chk++; if (rreq1_n !== r1) $display("FAIL en_noreq: got %0d ch1 reads expected 0", rreq1_n - r1); else n_pass++;
        ch_enable[1] = 1'b1;
        wait_acc(base + 7, 30, "en_resume");
        exp_w = '{wv(1,0), wv(1,1), wv(2,0), wv(2,1), wv(1,2), wv(1,3), wv(1,4)};
        exp_c = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
        for (int i = 0; i < 7; i++) begin
            n_chk++;
            if (acc_word[base+i] !== exp_w[i] || acc_ch[base+i] !== exp_c[i])
                $display("FAIL en_word%0d: got ch%0d %h expected ch%0d %h", i, acc_ch[base+i], acc_word[base+i], exp_c[i], exp_w[i]);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        int base;
        do_reset();
        base = acc_n;
        for (int k = 0; k < 6; k++) push(0, k);
        wait_acc(base + 2, 30, "ar_start");
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL ar_valid: got %b expected 0", out_valid); else n_pass++;
        n_chk++; if (ch_r_req !== 4'b0) $display("FAIL ar_rreq: got %b expected 0000", ch_r_req); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL ar_busy: got %b expected 0", busy); else n_pass++;
        push(2, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = acc_n;
        wait_acc(base + 1, 30, "ar_after");
        n_chk++;
        if (acc_ch[base] !== 2'd0 || acc_word[base] !== wv(0, 3))
            $display("FAIL ar_first: got ch%0d %h expected ch0 %h", acc_ch[base], acc_word[base], wv(0, 3));
        else n_pass++;
        wait_acc(base + 4, 40, "ar_drain");
    endtask

`ifdef FIFO_RR_SCHED_STATS_EN
    task automatic test_stats();
        int base;
        do_reset();
        base = acc_n;
        for (int k = 0; k < 20; k++) push(2, k);
        wait_acc(base + 20, 120, "st");
        repeat (3) @(negedge clk);
        for (int c = 0; c < CH_N; c++) begin
            n_chk++;
            if (stat_cnt[c*4 +: 4] !== ((c == 2) ? 4'hF : 4'h0))
                $display("FAIL stat%0d: got %0d expected %0d", c, stat_cnt[c*4 +: 4], (c == 2) ? 15 : 0);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        out_ready = 1'b1;
        ch_enable = '1;
        for (int c = 0; c < CH_N; c++) wr[c] = 0;
        for (int c = 0; c < CH_N; c++) rd[c] = 0;
        test_reset();
        test_burst_quota();
        test_round_robin();
        test_backpressure();
        test_enable_drop();
        test_async_reset();
`ifdef FIFO_RR_SCHED_STATS_EN
        test_stats();
`endif
        n_chk++;
        if (rd_empty_err !== 0) $display("FAIL empty_read: got %0d reads of empty FIFOs expected 0", rd_empty_err);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
